// File: rtl/pwm_cfg_sequencer.sv
// Operator front end for the 4-channel PWM driver: debounced BTN/SW edit events,
// shadow duty/mode settings, and a commit FSM that updates live outputs only on PERIOD_END.
module pwm_cfg_sequencer #(
    parameter int N_CH       = 4,
    parameter int DEB_CYCLES = 1000,
    parameter int DUTY_STEP  = 10,
    parameter int DUTY_MAX   = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     btn,
    input  logic [5:0]          sw,
    input  logic                period_end,
    output logic [7*N_CH-1:0]   duty,
    output logic                high_true,
    output logic                center_mode,
    output logic [1:0]          sel_ch,
    output logic                pending
);

    localparam int N_IN  = N_CH + 6;
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    logic [N_IN-1:0] sync_p0;
    logic [N_IN-1:0] sync_p1;
    logic [N_IN-1:0] stable_p2;
    logic [N_IN-1:0] prev_p3;
    logic [N_IN-1:0] evt_p3;
    logic [N_CH-1:0] btn_evt;
    logic [5:0]      sw_evt;

    logic [6:0] shadow [N_CH];
    logic       shadow_high;
    logic       shadow_center;

    logic [6:0] cur_duty;
    logic [6:0] nxt_duty;
    logic       nxt_high;
    logic       nxt_center;
    logic [1:0] nxt_sel;
    logic       edit;

    state_t state;

    function automatic logic [6:0] init_duty(input int ch);
        int d;
        d = 10 * (ch + 1);
        if (d > DUTY_MAX) d = DUTY_MAX;
        return 7'(d);
    endfunction

    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        logic [7:0] s;
        s = {1'b0, v} + 8'(DUTY_STEP);
        return (s > 8'(DUTY_MAX)) ? 7'(DUTY_MAX) : s[6:0];
    endfunction

    function automatic logic [6:0] sat_dec(input logic [6:0] v);
        return (v < 7'(DUTY_STEP)) ? 7'd0 : v - 7'(DUTY_STEP);
    endfunction

    // Stage 0/1: two-flop synchroniser on every raw input bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {sw, btn};
            sync_p1 <= sync_p0;
        end
    end

    // Stage 2: debouncer, accepts a change only after DEB_CYCLES consecutive disagreeing samples
    for (genvar i = 0; i < N_IN; i++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             stable;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                stable <= 1'b0;
            end else if (sync_p1[i] != stable) begin
                if (cnt == DEB_LAST) begin
                    stable <= sync_p1[i];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end

        assign stable_p2[i] = stable;
    end

    // Stage 3: one-cycle event on each accepted 0->1 transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_p3 <= '0;
            evt_p3  <= '0;
        end else begin
            prev_p3 <= stable_p2;
            evt_p3  <= stable_p2 & ~prev_p3;
        end
    end

    assign btn_evt = evt_p3[N_CH-1:0];
    assign sw_evt  = evt_p3[N_IN-1:N_CH];

    always_comb begin
        cur_duty   = shadow[sel_ch];
        nxt_duty   = cur_duty;
        nxt_high   = shadow_high;
        nxt_center = shadow_center;
        nxt_sel    = sel_ch;

        if (sw_evt[0] && !sw_evt[1]) begin
            nxt_duty = sat_inc(cur_duty);
        end else if (sw_evt[1] && !sw_evt[0]) begin
            nxt_duty = sat_dec(cur_duty);
        end

        if (sw_evt[2] && !sw_evt[3]) begin
            nxt_high = 1'b1;
        end else if (sw_evt[3] && !sw_evt[2]) begin
            nxt_high = 1'b0;
        end

        if (sw_evt[5] && !sw_evt[4]) begin
            nxt_center = 1'b1;
        end else if (sw_evt[4] && !sw_evt[5]) begin
            nxt_center = 1'b0;
        end

        // Descending scan so the lowest pressed index wins
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (btn_evt[i]) nxt_sel = 2'(i);
        end

        edit = (nxt_duty != cur_duty) || (nxt_high != shadow_high) ||
               (nxt_center != shadow_center);
    end

    // Stage 4: shadow settings and channel select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_ch <= 2'd0;
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= init_duty(i);
            end
            shadow_high   <= 1'b1;
            shadow_center <= 1'b0;
        end else begin
            sel_ch         <= nxt_sel;
            shadow[sel_ch] <= nxt_duty;
            shadow_high    <= nxt_high;
            shadow_center  <= nxt_center;
        end
    end

    // Commit FSM: committed registers take the pre-edit shadow on PERIOD_END
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                duty[7*i +: 7] <= init_duty(i);
            end
            high_true   <= 1'b1;
            center_mode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (edit) begin
                        state   <= PEND;
                        pending <= 1'b1;
                    end
                end
                PEND: begin
                    if (period_end) begin
                        for (int i = 0; i < N_CH; i++) begin
                            duty[7*i +: 7] <= shadow[i];
                        end
                        high_true   <= shadow_high;
                        center_mode <= shadow_center;
                        if (!edit) begin
                            state   <= IDLE;
                            pending <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Scoreboard bench for pwm_cfg_sequencer: stimulus queues expected full output snapshots
// with a due cycle; a monitor pops and compares them on the falling edge.
module tb_pwm_cfg_sequencer;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  in_vec;
    logic        period_end;
    logic [27:0] duty;
    logic        high_true;
    logic        center_mode;
    logic [1:0]  sel_ch;
    logic        pending;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;

    int          q_due[$];
    string       q_name[$];
    logic [32:0] q_exp[$];

    pwm_cfg_sequencer #(
        .N_CH(4),
        .DEB_CYCLES(DEB),
        .DUTY_STEP(10),
        .DUTY_MAX(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(in_vec[3:0]),
        .sw(in_vec[9:4]),
        .period_end(period_end),
        .duty(duty),
        .high_true(high_true),
        .center_mode(center_mode),
        .sel_ch(sel_ch),
        .pending(pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] btn_bit(input int i);
        return 10'(1) << i;
    endfunction

    function automatic logic [9:0] sw_bit(input int k);
        return 10'(1) << (4 + k);
    endfunction

    function automatic string fmt(input logic [32:0] v);
        return $sformatf("duty=%0d/%0d/%0d/%0d ht=%b cm=%b sel=%0d pend=%b",
                         v[11:5], v[18:12], v[25:19], v[32:26], v[4], v[3], v[2:1], v[0]);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [9:0] m);
        in_vec = m;
        tick(6);
        in_vec = '0;
        tick(8);
    endtask

    task automatic pulse_pe();
        period_end = 1'b1;
        tick(1);
        period_end = 1'b0;
    endtask

    task automatic expect_state(input string name, input int off,
                                input int d0, input int d1, input int d2, input int d3,
                                input logic ht, input logic cm,
                                input logic [1:0] sel, input logic pend);
        q_due.push_back(cyc + off);
        q_name.push_back(name);
        q_exp.push_back({7'(d3), 7'(d2), 7'(d1), 7'(d0), ht, cm, sel, pend});
    endtask

    initial begin : monitor
        logic [32:0] act;
        logic [32:0] exp_v;
        string       nm;
        int          due;
        forever begin
            @(negedge clk);
            while (q_due.size() > 0 && q_due[0] <= cyc) begin
                due   = q_due.pop_front();
                nm    = q_name.pop_front();
                exp_v = q_exp.pop_front();
                act   = {duty, high_true, center_mode, sel_ch, pending};
                n_vec++;
                if (act !== exp_v || due != cyc) begin
                    n_miss++;
                    $display("FAIL %s at cycle %0d (due %0d): got %s, want %s",
                             nm, cyc, due, fmt(act), fmt(exp_v));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached with %0d checks pending", q_due.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n      = 1'b0;
        in_vec     = '0;
        period_end = 1'b0;
        tick(1);
        expect_state("reset_init", 0, 10, 20, 30, 40, 1'b1, 1'b0, 2'd0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Short glitch is filtered, long press selects channel 2 exactly DEB+4 edges later
        expect_state("glitch_short", 12, 10, 20, 30, 40, 1'b1, 1'b0, 2'd0, 1'b0);
        in_vec = btn_bit(2);
        tick(3);
        in_vec = '0;
        tick(14);
        expect_state("btn2_pre", 7, 10, 20, 30, 40, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_state("btn2_sel", 8, 10, 20, 30, 40, 1'b1, 1'b0, 2'd2, 1'b0);
        in_vec = btn_bit(2);
        tick(20);
        in_vec = '0;
        tick(10);
        expect_state("btn2_held", 0, 10, 20, 30, 40, 1'b1, 1'b0, 2'd2, 1'b0);
        tick(1);

        // Asynchronous reset mid-cycle, checked before the next rising edge
        rst_n = 1'b0;
        expect_state("async_reset", 0, 10, 20, 30, 40, 1'b1, 1'b0, 2'd0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Commit on period boundary
        expect_state("sel_ch1", 8, 10, 20, 30, 40, 1'b1, 1'b0, 2'd1, 1'b0);
        press(btn_bit(1));
        expect_state("inc1_pend", 8, 10, 20, 30, 40, 1'b1, 1'b0, 2'd1, 1'b1);
        press(sw_bit(0));
        press(sw_bit(0));
        expect_state("inc3_hold", 8, 10, 20, 30, 40, 1'b1, 1'b0, 2'd1, 1'b1);
        press(sw_bit(0));
        expect_state("commit_pre", 0, 10, 20, 30, 40, 1'b1, 1'b0, 2'd1, 1'b1);
        expect_state("commit_post", 1, 10, 50, 30, 40, 1'b1, 1'b0, 2'd1, 1'b0);
        pulse_pe();
        tick(2);

        // Lower saturation
        expect_state("sel_ch0", 8, 10, 50, 30, 40, 1'b1, 1'b0, 2'd0, 1'b0);
        press(btn_bit(0));
        expect_state("dec_to0", 8, 10, 50, 30, 40, 1'b1, 1'b0, 2'd0, 1'b1);
        press(sw_bit(1));
        press(sw_bit(1));
        pulse_pe();
        expect_state("commit_zero", 0, 0, 50, 30, 40, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_state("dec_noop", 8, 0, 50, 30, 40, 1'b1, 1'b0, 2'd0, 1'b0);
        press(sw_bit(1));

        // Upper saturation
        expect_state("sel_ch3", 8, 0, 50, 30, 40, 1'b1, 1'b0, 2'd3, 1'b0);
        press(btn_bit(3));
        repeat (6) press(sw_bit(0));
        expect_state("inc_sat", 8, 0, 50, 30, 40, 1'b1, 1'b0, 2'd3, 1'b1);
        press(sw_bit(0));
        pulse_pe();
        expect_state("commit_100", 0, 0, 50, 30, 100, 1'b1, 1'b0, 2'd3, 1'b0);
        expect_state("inc_noop", 8, 0, 50, 30, 100, 1'b1, 1'b0, 2'd3, 1'b0);
        press(sw_bit(0));

        // Edit event on the same edge as PERIOD_END
        expect_state("sel_ch0b", 8, 0, 50, 30, 100, 1'b1, 1'b0, 2'd0, 1'b0);
        press(btn_bit(0));
        press(sw_bit(0));
        pulse_pe();
        expect_state("commit_10", 0, 10, 50, 30, 100, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_state("pend_20", 8, 10, 50, 30, 100, 1'b1, 1'b0, 2'd0, 1'b1);
        press(sw_bit(0));
        expect_state("collide_pre", 7, 10, 50, 30, 100, 1'b1, 1'b0, 2'd0, 1'b1);
        expect_state("collide_commit", 8, 20, 50, 30, 100, 1'b1, 1'b0, 2'd0, 1'b1);
        in_vec = sw_bit(0);
        tick(6);
        in_vec = '0;
        tick(1);
        period_end = 1'b1;
        tick(1);
        period_end = 1'b0;
        tick(6);
        pulse_pe();
        expect_state("commit_30", 0, 30, 50, 30, 100, 1'b1, 1'b0, 2'd0, 1'b0);

        // Mode fields, paired events and button priority
        expect_state("pol_pend", 8, 30, 50, 30, 100, 1'b1, 1'b0, 2'd0, 1'b1);
        press(sw_bit(3));
        press(sw_bit(5));
        pulse_pe();
        expect_state("mode_commit", 0, 30, 50, 30, 100, 1'b0, 1'b1, 2'd0, 1'b0);
        expect_state("pair_pol", 8, 30, 50, 30, 100, 1'b0, 1'b1, 2'd0, 1'b0);
        press(sw_bit(2) | sw_bit(3));
        expect_state("pair_align", 8, 30, 50, 30, 100, 1'b0, 1'b1, 2'd0, 1'b0);
        press(sw_bit(4) | sw_bit(5));
        expect_state("pair_duty", 8, 30, 50, 30, 100, 1'b0, 1'b1, 2'd0, 1'b0);
        press(sw_bit(0) | sw_bit(1));
        expect_state("btn_prio", 8, 30, 50, 30, 100, 1'b0, 1'b1, 2'd1, 1'b0);
        press(btn_bit(1) | btn_bit(3));

        // Reset while an edit is pending
        expect_state("sel_ch2", 8, 30, 50, 30, 100, 1'b0, 1'b1, 2'd2, 1'b0);
        press(btn_bit(2));
        expect_state("edit_ch2", 8, 30, 50, 30, 100, 1'b0, 1'b1, 2'd2, 1'b1);
        press(sw_bit(0));
        rst_n = 1'b0;
        expect_state("reset_pend", 0, 10, 20, 30, 40, 1'b1, 1'b0, 2'd0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        pulse_pe();
        expect_state("pe_after_reset", 0, 10, 20, 30, 40, 1'b1, 1'b0, 2'd0, 1'b0);
        tick(4);

        for (int i = 0; i < 50 && q_due.size() > 0; i++) tick(1);
        if (q_due.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, want 0", q_due.size());
            n_miss += q_due.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
